// File: rtl/qu_decode_stage_pkg.sv
// qu_decode_stage_pkg: instruction classes, opcodes and decoded-entry layout shared by the decode stage.
package qu_decode_stage_pkg;
  typedef enum logic [3:0] {
    IC_R, IC_I_ALU, IC_LOAD, IC_STORE, IC_BRANCH, IC_JAL, IC_JALR,
    IC_LUI, IC_AUIPC, IC_CSR, IC_SYSTEM, IC_FENCE, IC_ILLEGAL
  } iclass_t;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  typedef struct packed {
    iclass_t     iclass;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rd_valid;
    logic        rs1_valid;
    logic        rs2_valid;
    logic        imm_valid;
    logic [31:0] imm;
    logic        illegal;
  } decoded_instr_t;
endpackage

// File: rtl/qu_instr_field_decode.sv
// qu_instr_field_decode: combinational RV32I field extraction, classification and illegal detection.
module qu_instr_field_decode
  import qu_decode_stage_pkg::*;
#(
  parameter bit CHECK_ILLEGAL = 1'b1
) (
  input  logic [31:0]    instr_i,
  output decoded_instr_t dec_o
);
  logic [6:0] op, f7;
  logic [2:0] f3;
  logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm, z_imm, imm;
  iclass_t cls;
  logic rdv, rs1v, rs2v, immv, bad, ill;
  assign op = instr_i[6:0];
  assign f3 = instr_i[14:12];
  assign f7 = instr_i[31:25];
  assign i_imm = {{20{instr_i[31]}}, instr_i[31:20]};
  assign s_imm = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign b_imm = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign u_imm = {instr_i[31:12], 12'b0};
  assign j_imm = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
  assign z_imm = {20'b0, instr_i[31:20]};
  always_comb begin
    cls  = IC_ILLEGAL;
    rdv  = 1'b0;
    rs1v = 1'b0;
    rs2v = 1'b0;
    immv = 1'b0;
    imm  = '0;
    bad  = 1'b0;
    case (op)
      OP_LUI:    begin cls = IC_LUI;   rdv = 1'b1; immv = 1'b1; imm = u_imm; end
      OP_AUIPC:  begin cls = IC_AUIPC; rdv = 1'b1; immv = 1'b1; imm = u_imm; end
      OP_JAL:    begin cls = IC_JAL;   rdv = 1'b1; immv = 1'b1; imm = j_imm; end
      OP_JALR:   begin cls = IC_JALR;  rdv = 1'b1; rs1v = 1'b1; immv = 1'b1; imm = i_imm; bad = f3 != 3'b000; end
      OP_BRANCH: begin cls = IC_BRANCH; rs1v = 1'b1; rs2v = 1'b1; immv = 1'b1; imm = b_imm; bad = f3[2:1] == 2'b01; end
      OP_LOAD:   begin cls = IC_LOAD;  rdv = 1'b1; rs1v = 1'b1; immv = 1'b1; imm = i_imm; bad = f3 == 3'b011 || f3[2:1] == 2'b11; end
      OP_STORE:  begin cls = IC_STORE; rs1v = 1'b1; rs2v = 1'b1; immv = 1'b1; imm = s_imm; bad = f3 > 3'b010; end
      OP_OPIMM: begin
        cls = IC_I_ALU; rdv = 1'b1; rs1v = 1'b1; immv = 1'b1; imm = i_imm;
        bad = (f3 == 3'b001 && f7 != 7'h00) || (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20);
      end
      OP_OP: begin
        cls = IC_R; rdv = 1'b1; rs1v = 1'b1; rs2v = 1'b1;
        bad = (f7 != 7'h00 && f7 != 7'h20) || (f7 == 7'h20 && f3 != 3'b000 && f3 != 3'b101);
      end
      OP_FENCE:  begin cls = IC_FENCE; immv = 1'b1; imm = z_imm; bad = f3 > 3'b001; end
      // funct3 000 is ECALL/EBREAK (imm 0/1); the rest are CSR ops, immediate forms carry uimm in rs1
      OP_SYSTEM: begin
        cls  = f3 == 3'b000 ? IC_SYSTEM : IC_CSR;
        rdv  = f3 != 3'b000;
        rs1v = f3 != 3'b000 && !f3[2];
        immv = 1'b1;
        imm  = z_imm;
        bad  = f3 == 3'b100 || (f3 == 3'b000 && instr_i[31:20] > 12'd1);
      end
      default: bad = 1'b1;
    endcase
  end
  assign ill = CHECK_ILLEGAL && bad;
  always_comb begin
    dec_o.iclass    = ill ? IC_ILLEGAL : cls;
    dec_o.funct3    = f3;
    dec_o.funct7    = f7;
    dec_o.rd        = instr_i[11:7];
    dec_o.rs1       = instr_i[19:15];
    dec_o.rs2       = instr_i[24:20];
    dec_o.rd_valid  = rdv && !ill && instr_i[11:7] != 5'd0;
    dec_o.rs1_valid = rs1v && !ill;
    dec_o.rs2_valid = rs2v && !ill;
    dec_o.imm_valid = immv && !ill;
    dec_o.imm       = imm;
    dec_o.illegal   = ill;
  end
endmodule

// File: rtl/qu_decode_stage.sv
// qu_decode_stage: registered RV32I decode with valid/ready handshakes, a one-entry skid buffer and flush.
module qu_decode_stage
  import qu_decode_stage_pkg::*;
#(
  parameter int PC_WIDTH      = 12,
  parameter bit CHECK_ILLEGAL = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush_i,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic [31:0]         instr_i,
  input  logic [PC_WIDTH-1:0] pc_i,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [PC_WIDTH-1:0] pc_o,
  output logic [3:0]          iclass_o,
  output logic [2:0]          funct3_o,
  output logic [6:0]          funct7_o,
  output logic [4:0]          rd_o,
  output logic [4:0]          rs1_o,
  output logic [4:0]          rs2_o,
  output logic                rd_valid_o,
  output logic                rs1_valid_o,
  output logic                rs2_valid_o,
  output logic                imm_valid_o,
  output logic [31:0]         imm_o,
  output logic                illegal_o
);
  decoded_instr_t dec, out_d, out_q, skid_d, skid_q;
  logic [PC_WIDTH-1:0] out_pc_d, out_pc_q, skid_pc_d, skid_pc_q;
  logic out_valid_d, out_valid_q, skid_valid_d, skid_valid_q;
  logic acc, drain, load_out, load_skid;
  qu_instr_field_decode #(.CHECK_ILLEGAL(CHECK_ILLEGAL)) u_field_decode (
    .instr_i(instr_i),
    .dec_o  (dec)
  );
  // the skid only fills while the output is stalled, and ready_o is low whenever it is full
  always_comb begin
    acc          = valid_i && !skid_valid_q;
    drain        = !out_valid_q || ready_i;
    load_out     = !flush_i && drain && (skid_valid_q || acc);
    load_skid    = !flush_i && !drain && acc;
    out_valid_d  = flush_i ? 1'b0 : (drain ? (skid_valid_q || acc) : 1'b1);
    skid_valid_d = !flush_i && !drain && (skid_valid_q || acc);
    out_d        = load_out ? (skid_valid_q ? skid_q : dec) : out_q;
    out_pc_d     = load_out ? (skid_valid_q ? skid_pc_q : pc_i) : out_pc_q;
    skid_d       = load_skid ? dec : skid_q;
    skid_pc_d    = load_skid ? pc_i : skid_pc_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_q        <= '0;
      out_pc_q     <= '0;
      skid_q       <= '0;
      skid_pc_q    <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      out_q        <= out_d;
      out_pc_q     <= out_pc_d;
      skid_q       <= skid_d;
      skid_pc_q    <= skid_pc_d;
    end
  end
  assign ready_o     = !skid_valid_q;
  assign valid_o     = out_valid_q;
  assign pc_o        = out_pc_q;
  assign iclass_o    = out_q.iclass;
  assign funct3_o    = out_q.funct3;
  assign funct7_o    = out_q.funct7;
  assign rd_o        = out_q.rd;
  assign rs1_o       = out_q.rs1;
  assign rs2_o       = out_q.rs2;
  assign rd_valid_o  = out_q.rd_valid;
  assign rs1_valid_o = out_q.rs1_valid;
  assign rs2_valid_o = out_q.rs2_valid;
  assign imm_valid_o = out_q.imm_valid;
  assign imm_o       = out_q.imm;
  assign illegal_o   = out_q.illegal;
endmodule
